// File: rtl/lc3_regfile_sb.sv
// LC-3 register file with a pending-write scoreboard and a register dump FSM.
// Define LC3_RF_BYPASS_EN to forward same-cycle writeback into reads and issue_ready.
module lc3_regfile_sb #(
  parameter int                 DATA_W    = 16,
  parameter int                 NREGS     = 8,
  parameter int                 NRD       = 2,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  localparam int                AW        = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_addr,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [NREGS-1:0]      busy_vec,
  input  logic                  dump_start,
  output logic                  dump_valid,
  output logic [AW-1:0]         dump_addr,
  output logic [DATA_W-1:0]     dump_data,
  output logic                  dump_done
);

  typedef enum logic {
    IDLE,
    SCAN
  } dump_state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_n;
  logic              issue_fire;

  dump_state_t       state, state_n;
  logic [AW-1:0]     idx, idx_n;
  logic              valid_n, done_n;
  logic [AW-1:0]     addr_n;
  logic [DATA_W-1:0] data_n;

  assign busy_vec = busy;

`ifdef LC3_RF_BYPASS_EN
  logic wb_hit_issue;
  assign wb_hit_issue = wb_valid && (wb_addr == issue_addr);
  assign issue_ready  = !busy[issue_addr] || wb_hit_issue;
`else
  assign issue_ready  = !busy[issue_addr];
`endif

  assign issue_fire = issue_valid && issue_ready;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[p*AW +: AW];
`ifdef LC3_RF_BYPASS_EN
    logic hit;
    assign hit = wb_valid && (wb_addr == a);
    assign rd_data[p*DATA_W +: DATA_W] = hit ? wb_data : regs[a];
    assign rd_busy[p] = busy[a] && !hit;
`else
    assign rd_data[p*DATA_W +: DATA_W] = regs[a];
    assign rd_busy[p] = busy[a];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
    end else if (wb_valid) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // The issue set is applied after the writeback clear so it wins on a collision.
  always_comb begin
    busy_n = busy;
    if (wb_valid)   busy_n[wb_addr]    = 1'b0;
    if (issue_fire) busy_n[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      dump_valid <= valid_n;
      dump_done  <= done_n;
      dump_addr  <= addr_n;
      dump_data  <= data_n;
    end
  end

  // Beats sample the array combinationally, so a same-edge write is not seen.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    valid_n = 1'b0;
    done_n  = 1'b0;
    addr_n  = dump_addr;
    data_n  = dump_data;
    case (state)
      IDLE: begin
        if (dump_start) begin
          state_n = SCAN;
          idx_n   = '0;
        end
      end
      SCAN: begin
        valid_n = 1'b1;
        addr_n  = idx;
        data_n  = regs[idx];
        idx_n   = idx + 1'b1;
        if (idx == LAST_IDX) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Directed self-checking bench for lc3_regfile_sb (default parameters).
// Expectations follow LC3_RF_BYPASS_EN when the bench is built with it.
module tb_lc3_regfile_sb;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int NRD    = 2;
  localparam int AW     = 3;
`ifdef LC3_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  issue_valid;
  logic [AW-1:0]         issue_addr;
  logic                  issue_ready;
  logic                  wb_valid;
  logic [AW-1:0]         wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic [NREGS-1:0]      busy_vec;
  logic                  dump_start;
  logic                  dump_valid;
  logic [AW-1:0]         dump_addr;
  logic [DATA_W-1:0]     dump_data;
  logic                  dump_done;

  int checks   = 0;
  int failures = 0;

  lc3_regfile_sb #(
    .DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .RESET_VAL(16'h0000)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_vec(busy_vec),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wbv, input logic [AW-1:0] wba,
                               input logic [DATA_W-1:0] wbd,
                               input logic iv, input logic [AW-1:0] ia);
    wb_valid    = wbv;
    wb_addr     = wba;
    wb_data     = wbd;
    issue_valid = iv;
    issue_addr  = ia;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int seen_valid;
    int seen_done;

    rst = 1'b1;
    rd_addr = '0;
    dump_start = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    stepCycle();
    stepCycle();
    rst = 1'b0;

    // Reset clears the array, scoreboard and dump outputs and beats wb/issue
    applyStimulus(1'b1, 3'd3, 16'h1234, 1'b1, 3'd1);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    rd_addr = {3'd0, 3'd3};
    #1;
    checkOutput("pre_rst_r3", 32'(rd_data[15:0]), 32'h1234);
    checkOutput("pre_rst_busy", 32'(busy_vec), 32'h02);
    rst = 1'b1;
    applyStimulus(1'b1, 3'd3, 16'h5555, 1'b1, 3'd6);
    stepCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    #1;
    checkOutput("rst_rd0", 32'(rd_data[15:0]), 32'h0);
    checkOutput("rst_rd1", 32'(rd_data[31:16]), 32'h0);
    checkOutput("rst_busy", 32'(busy_vec), 32'h0);
    checkOutput("rst_dvalid", 32'(dump_valid), 32'h0);
    checkOutput("rst_ddone", 32'(dump_done), 32'h0);
    checkOutput("rst_daddr", 32'(dump_addr), 32'h0);
    checkOutput("rst_ddata", 32'(dump_data), 32'h0);

    // Bypass: R5 written and issued together, then overwritten while read
    applyStimulus(1'b1, 3'd5, 16'h1111, 1'b1, 3'd5);
    stepCycle();
    checkOutput("wb_issue_r5_busy", 32'(busy_vec), 32'h20);
    applyStimulus(1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0);
    rd_addr = {3'd3, 3'd5};
    #1;
    checkOutput("byp_rd0", 32'(rd_data[15:0]), BYP ? 32'hBEEF : 32'h1111);
    checkOutput("byp_rdbusy0", 32'(rd_busy[0]), BYP ? 32'h0 : 32'h1);
    checkOutput("byp_rd1", 32'(rd_data[31:16]), 32'h0);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    #1;
    checkOutput("post_wb_rd0", 32'(rd_data[15:0]), 32'hBEEF);
    checkOutput("post_wb_rdbusy0", 32'(rd_busy[0]), 32'h0);
    checkOutput("post_wb_busy", 32'(busy_vec), 32'h0);

    // Scoreboard: issue, refused re-issue, writeback clear
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd2);
    #1;
    checkOutput("iss_r2_ready", 32'(issue_ready), 32'h1);
    stepCycle();
    checkOutput("iss_r2_busy", 32'(busy_vec), 32'h04);
    rd_addr = {3'd2, 3'd0};
    #1;
    checkOutput("iss_r2_rdbusy1", 32'(rd_busy[1]), 32'h1);
    checkOutput("reiss_r2_ready", 32'(issue_ready), 32'h0);
    stepCycle();
    checkOutput("reiss_r2_busy", 32'(busy_vec), 32'h04);
    applyStimulus(1'b1, 3'd2, 16'h2222, 1'b0, 3'd0);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    #1;
    checkOutput("wb_r2_busy", 32'(busy_vec), 32'h0);
    checkOutput("wb_r2_rd1", 32'(rd_data[31:16]), 32'h2222);

    // Same-cycle writeback and issue to a pending R4
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
    stepCycle();
    checkOutput("iss_r4_busy", 32'(busy_vec), 32'h10);
    applyStimulus(1'b1, 3'd4, 16'h4444, 1'b1, 3'd4);
    #1;
    checkOutput("coll_r4_ready", 32'(issue_ready), BYP ? 32'h1 : 32'h0);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    rd_addr = {3'd0, 3'd4};
    #1;
    checkOutput("coll_r4_busy", 32'(busy_vec), BYP ? 32'h10 : 32'h00);
    checkOutput("coll_r4_data", 32'(rd_data[15:0]), 32'h4444);

    // Dump: fill Ri = 0x0100+i, then stream; restart request and R6 write mid-scan
    for (int i = 0; i < NREGS; i++) begin
      applyStimulus(1'b1, 3'(i), 16'h0100 + 16'(i), 1'b0, 3'd0);
      stepCycle();
    end
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    dump_start = 1'b1;
    stepCycle();
    dump_start = 1'b0;
    checkOutput("dump_wait_valid", 32'(dump_valid), 32'h0);
    for (int b = 0; b < NREGS; b++) begin
      dump_start = (b == 3);
      if (b == 6) applyStimulus(1'b1, 3'd6, 16'hAAAA, 1'b0, 3'd0);
      else        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
      stepCycle();
      checkOutput($sformatf("beat%0d_valid", b), 32'(dump_valid), 32'h1);
      checkOutput($sformatf("beat%0d_addr", b), 32'(dump_addr), 32'(b));
      checkOutput($sformatf("beat%0d_data", b), 32'(dump_data), 32'h0100 + 32'(b));
      checkOutput($sformatf("beat%0d_done", b), 32'(dump_done), (b == 7) ? 32'h1 : 32'h0);
    end
    dump_start = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    stepCycle();
    checkOutput("dump_end_valid", 32'(dump_valid), 32'h0);
    checkOutput("dump_end_done", 32'(dump_done), 32'h0);
    rd_addr = {3'd0, 3'd6};
    #1;
    checkOutput("dump_r6_written", 32'(rd_data[15:0]), 32'hAAAA);

    // Reset at beat 3 aborts the dump without a done pulse
    dump_start = 1'b1;
    stepCycle();
    dump_start = 1'b0;
    for (int b = 0; b < 4; b++) stepCycle();
    checkOutput("abort_beat3_addr", 32'(dump_addr), 32'h3);
    checkOutput("abort_beat3_data", 32'(dump_data), 32'h0103);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("abort_valid", 32'(dump_valid), 32'h0);
    checkOutput("abort_done", 32'(dump_done), 32'h0);
    checkOutput("abort_addr", 32'(dump_addr), 32'h0);
    checkOutput("abort_r6", 32'(rd_data[15:0]), 32'h0);
    seen_valid = 0;
    seen_done  = 0;
    for (int c = 0; c < 10; c++) begin
      stepCycle();
      if (dump_valid) seen_valid++;
      if (dump_done)  seen_done++;
    end
    checkOutput("abort_idle_valid", 32'(seen_valid), 32'h0);
    checkOutput("abort_idle_done", 32'(seen_done), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
